// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and helpers for uart_rx_fsm
//
// Contents:
//   rx_state_e       receiver frame state. The PARITY state exists only when
//                    UART_RX_FSM_PARITY_EN is defined.
//   PRESCALE_*       legal oversampling ratios (4, 8, 16, 32).
//   prescale_legal() returns 1 when a Prescale value is one of the legal ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_FSM_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned PRESCALE_4  = 4;
  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic logic prescale_legal(input logic [31:0] p);
    return (p == PRESCALE_4) || (p == PRESCALE_8) ||
           (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive frame sequencer
//
// Walks a serial frame (start, DATA_BITS data, optional parity, stop) using the
// edge count from an external oversampling counter. It fires single-cycle
// strobes to the checkers and deserializer, then issues one registered
// frame-result pulse.
//
// Optional feature: define UART_RX_FSM_PARITY_EN to include the PARITY state and
// honour PAR_EN. When it is undefined, PAR_EN and par_err are ignored and
// par_chk_en stays 0.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous active-high reset
//   RX_IN        serial line, idle high
//   PAR_EN       parity bit present in frame (sampled at the last data bit)
//   Prescale     oversampling ratio; legal values 4/8/16/32
//   edge_cnt     edge count within the current bit, 0..Prescale-1
//   strt_glitch  start-bit checker result, valid with strt_chk_en
//   par_err      parity checker result, valid with par_chk_en
//   stp_err      stop-bit checker result, valid with stp_chk_en
//   cnt_enable   edge counter enable; low holds the counter cleared
//   dat_samp_en  sampler enable
//   deser_en     deserializer shift strobe, one per data bit
//   strt_chk_en  start check strobe
//   par_chk_en   parity check strobe
//   stp_chk_en   stop check strobe
//   data_valid   registered pulse: frame received without error
//   frame_err    registered pulse: stop/parity error or mid-frame Prescale change
//   cfg_err      registered: current Prescale is illegal
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 5,
  parameter int DATA_BITS  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [EDGE_W-1:0]     edge_cnt,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  cnt_enable,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  cfg_err
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_e             state;
  rx_state_e             state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  perr_q;
  logic                  bit_end;
  logic                  pre_legal;
  logic                  abort;

  assign pre_legal = prescale_legal(32'(Prescale));
  assign bit_end   = (edge_cnt == EDGE_W'(Prescale - PRESCALE_W'(1)));

`ifndef UART_RX_FSM_PARITY_EN
  logic unused_par;
  assign unused_par = ^{PAR_EN, par_err};
  assign perr_q     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      pre_q      <= '0;
`ifdef UART_RX_FSM_PARITY_EN
      perr_q     <= 1'b0;
`endif
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      // The ratio in force for the whole frame is fixed at the start edge.
      if (state == IDLE && state_nxt == START) begin
        pre_q <= Prescale;
      end
      // Index sits at 0 outside DATA and saturates at the last bit.
      if (state != DATA) begin
        idx <= '0;
      end else if (deser_en && idx != IDX_LAST) begin
        idx <= idx + IDX_W'(1);
      end
`ifdef UART_RX_FSM_PARITY_EN
      if (state == IDLE) begin
        perr_q <= 1'b0;
      end else if (par_chk_en) begin
        perr_q <= par_err;
      end
`endif
      data_valid <= stp_chk_en && !stp_err && !perr_q;
      frame_err  <= abort || (stp_chk_en && (stp_err || perr_q));
      cfg_err    <= !pre_legal;
    end
  end

  always_comb begin
    state_nxt   = state;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    abort       = 1'b0;
    cnt_enable  = (state != IDLE);
    dat_samp_en = (state != IDLE);

    case (state)
      IDLE: begin
        if (!RX_IN && pre_legal) state_nxt = START;
      end
      START: begin
        if (bit_end) begin
          strt_chk_en = 1'b1;
          state_nxt   = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          deser_en = 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_FSM_PARITY_EN
            state_nxt = PAR_EN ? PARITY : STOP;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_FSM_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          par_chk_en = 1'b1;
          state_nxt  = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          stp_chk_en = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A ratio change mid-frame makes bit timing meaningless: drop the frame
    // and report it, without letting any checker act on this cycle.
    if (state != IDLE && Prescale != pre_q) begin
      abort       = 1'b1;
      state_nxt   = IDLE;
      strt_chk_en = 1'b0;
      deser_en    = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
    end

    if (RST) begin
      strt_chk_en = 1'b0;
      deser_en    = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;

  localparam int PW = 6;
  localparam int EW = 5;
`ifdef UART_RX_FSM_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  typedef struct {
    logic       ok;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_pop;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic [PW-1:0] Prescale = 6'd8;
  logic [EW-1:0] edge_cnt = '0;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          cnt_enable, dat_samp_en, deser_en, strt_chk_en;
  logic          par_chk_en, stp_chk_en, data_valid, frame_err, cfg_err;

  uart_rx_fsm dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .edge_cnt(edge_cnt), .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .cnt_enable(cnt_enable), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .frame_err(frame_err), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Edge/bit counter that sits beside the FSM in the receiver.
  always @(posedge CLK) begin
    if (cnt_enable !== 1'b1) edge_cnt <= '0;
    else if (edge_cnt == EW'(Prescale - 6'd1)) edge_cnt <= '0;
    else edge_cnt <= edge_cnt + 5'd1;
  end

  // Monitor: deserializer model plus scoreboard pop on each result pulse.
  logic [7:0] shreg = '0;
  int n_deser = 0, n_dv = 0, n_fe = 0, n_par = 0, n_strt = 0;
  int deser_cyc[$];
  int stp_cyc = -1, dv_cyc = -1;

  initial begin
    forever begin
      @(negedge CLK);
      if (deser_en === 1'b1) begin
        shreg = {RX_IN, shreg[7:1]};
        n_deser++;
        deser_cyc.push_back(cyc);
      end
      if (par_chk_en === 1'b1) n_par++;
      if (strt_chk_en === 1'b1) n_strt++;
      if (stp_chk_en === 1'b1) stp_cyc = cyc;
      if (data_valid === 1'b1 || frame_err === 1'b1) begin
        checks++;
        if (data_valid === 1'b1 && frame_err === 1'b1) begin
          errors++;
          $display("FAIL result_exclusive: data_valid=%b frame_err=%b, required not both", data_valid, frame_err);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: data_valid=%b frame_err=%b, required no pulse", data_valid, frame_err);
        end else begin
          e_pop = exp_q.pop_front();
          if (data_valid !== e_pop.ok || (e_pop.ok && shreg !== e_pop.data)) begin
            errors++;
            $display("FAIL frame_result: dv=%b data=%h, required dv=%b data=%h", data_valid, shreg, e_pop.ok, e_pop.data);
          end
        end
        if (data_valid === 1'b1) begin
          n_dv++;
          dv_cyc = cyc;
        end
        if (frame_err === 1'b1) n_fe++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic ok, input logic [7:0] d);
    exp_t x;
    x.ok = ok;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic with_par);
    RX_IN = 1'b0;
    tick(1);
    tick(p);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      tick(p);
    end
    if (with_par && HAS_PAR) begin
      RX_IN = ^d;
      tick(p);
    end
    RX_IN = 1'b1;
    tick(p);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    Prescale = 6'd8;
    RX_IN = 1'b1;
    tick(2);
    checks++;
    if ({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, cfg_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000000",
               {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, cfg_err});
    end
    RST = 1'b0;
    tick(2);
    checks++;
    if ({cnt_enable, cfg_err} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: cnt_enable/cfg_err=%b, required 00", {cnt_enable, cfg_err});
    end
  endtask

  task automatic test_basic_frame;
    int nd0;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    tick(2);
    nd0 = n_deser;
    deser_cyc.delete();
    push_exp(1'b1, 8'h55);
    send_frame(8'h55, 8, 1'b0);
    tick(1);
    checks++;
    if (n_deser - nd0 != 8) begin
      errors++;
      $display("FAIL basic_deser_count: got %0d, required 8", n_deser - nd0);
    end
    for (int i = 1; i < deser_cyc.size(); i++) begin
      checks++;
      if (deser_cyc[i] - deser_cyc[i-1] != 8) begin
        errors++;
        $display("FAIL basic_deser_spacing: pulse %0d gap %0d, required 8", i, deser_cyc[i] - deser_cyc[i-1]);
      end
    end
    checks++;
    if (dv_cyc - stp_cyc != 1) begin
      errors++;
      $display("FAIL basic_dv_latency: got %0d, required 1", dv_cyc - stp_cyc);
    end
    check_drained("basic");
  endtask

  task automatic test_parity_err;
    int np0;
    Prescale = 6'd16;
    PAR_EN = 1'b1;
    par_err = 1'b1;
    tick(2);
    np0 = n_par;
    push_exp(!HAS_PAR, 8'hC5);
    send_frame(8'hC5, 16, 1'b1);
    tick(1);
    checks++;
    if (n_par - np0 != int'(HAS_PAR)) begin
      errors++;
      $display("FAIL parity_chk_count: got %0d, required %0d", n_par - np0, int'(HAS_PAR));
    end
    check_drained("parity_err");
    par_err = 1'b0;
    push_exp(1'b1, 8'h96);
    send_frame(8'h96, 16, 1'b1);
    tick(1);
    check_drained("parity_ok");
    PAR_EN = 1'b0;
  endtask

  task automatic test_stop_err;
    Prescale = 6'd16;
    stp_err = 1'b1;
    tick(1);
    push_exp(1'b0, 8'h0F);
    send_frame(8'h0F, 16, 1'b0);
    tick(1);
    stp_err = 1'b0;
    check_drained("stop_err");
  endtask

  task automatic test_start_glitch;
    int nd0, ns0;
    Prescale = 6'd4;
    strt_glitch = 1'b1;
    tick(2);
    nd0 = n_deser;
    ns0 = n_strt;
    RX_IN = 1'b0;
    tick(1);
    RX_IN = 1'b1;
    tick(3);
    checks++;
    if (strt_chk_en !== 1'b1) begin
      errors++;
      $display("FAIL glitch_strt_chk: got %b, required 1", strt_chk_en);
    end
    tick(1);
    checks++;
    if ({cnt_enable, dat_samp_en} !== 2'b00) begin
      errors++;
      $display("FAIL glitch_idle: cnt_enable/dat_samp_en=%b, required 00", {cnt_enable, dat_samp_en});
    end
    tick(10);
    checks++;
    if (n_deser - nd0 != 0 || n_strt - ns0 != 1) begin
      errors++;
      $display("FAIL glitch_strobes: deser=%0d strt=%0d, required 0 and 1", n_deser - nd0, n_strt - ns0);
    end
    strt_glitch = 1'b0;
  endtask

  task automatic test_prescale_change;
    int nd0, nf0;
    logic [7:0] d;
    d = 8'h3A;
    Prescale = 6'd8;
    tick(2);
    nd0 = n_deser;
    nf0 = n_fe;
    push_exp(1'b0, 8'h00);
    RX_IN = 1'b0;
    tick(1);
    tick(8);
    for (int i = 0; i < 3; i++) begin
      RX_IN = d[i];
      tick(8);
    end
    RX_IN = d[3];
    tick(2);
    Prescale = 6'd16;
    RX_IN = 1'b1;
    #1;
    checks++;
    if ({deser_en, strt_chk_en, par_chk_en, stp_chk_en} !== 4'b0) begin
      errors++;
      $display("FAIL change_strobes: got %b, required 0000", {deser_en, strt_chk_en, par_chk_en, stp_chk_en});
    end
    tick(1);
    checks++;
    if ({cnt_enable, frame_err} !== 2'b01) begin
      errors++;
      $display("FAIL change_abort: cnt_enable/frame_err=%b, required 01", {cnt_enable, frame_err});
    end
    Prescale = 6'd8;
    tick(12);
    checks++;
    if (n_deser - nd0 != 3 || n_fe - nf0 != 1) begin
      errors++;
      $display("FAIL change_counts: deser=%0d frame_err=%0d, required 3 and 1", n_deser - nd0, n_fe - nf0);
    end
    check_drained("prescale_change");
  endtask

  task automatic test_cfg_and_reset;
    int nd0, nv0, nf0;
    logic [7:0] d;
    d = 8'hB2;
    Prescale = 6'd6;
    tick(2);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_set: got %b, required 1", cfg_err);
    end
    RX_IN = 1'b0;
    tick(4);
    checks++;
    if (cnt_enable !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ignore_rx: cnt_enable=%b, required 0", cnt_enable);
    end
    RX_IN = 1'b1;
    Prescale = 6'd8;
    tick(2);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear: got %b, required 0", cfg_err);
    end
    nd0 = n_deser;
    nv0 = n_dv;
    nf0 = n_fe;
    RX_IN = 1'b0;
    tick(1);
    tick(8);
    for (int i = 0; i < 5; i++) begin
      RX_IN = d[i];
      tick(8);
    end
    RX_IN = d[5];
    tick(3);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    RX_IN = 1'b1;
    checks++;
    if ({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, cfg_err} !== 9'b0) begin
      errors++;
      $display("FAIL midframe_reset: got %b, required 000000000",
               {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, cfg_err});
    end
    tick(40);
    checks++;
    if (n_deser - nd0 != 5 || n_dv != nv0 || n_fe != nf0) begin
      errors++;
      $display("FAIL midframe_reset_counts: deser=%0d dv=%0d fe=%0d, required 5 0 0", n_deser - nd0, n_dv - nv0, n_fe - nf0);
    end
  endtask

  task automatic test_back_to_back;
    int nv0;
    Prescale = 6'd32;
    PAR_EN = 1'b0;
    tick(2);
    nv0 = n_dv;
    push_exp(1'b1, 8'hA3);
    push_exp(1'b1, 8'h3C);
    send_frame(8'hA3, 32, 1'b0);
    send_frame(8'h3C, 32, 1'b0);
    RX_IN = 1'b1;
    tick(2);
    checks++;
    if (n_dv - nv0 != 2) begin
      errors++;
      $display("FAIL b2b_dv_count: got %0d, required 2", n_dv - nv0);
    end
    check_drained("back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_err();
    test_stop_err();
    test_start_glitch();
    test_prescale_change();
    test_cfg_and_reset();
    test_back_to_back();
    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: PRESCALE_W, default 6, width of Prescale.
REQ-002 Parameter: EDGE_W, default 5, width of edge_cnt.
REQ-003 Parameter: DATA_BITS, default 8, data bits per frame.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port: CLK  in  1  rising-edge clock.
REQ-006 Port: RST  in  1  synchronous active-high reset.
REQ-007 Port: RX_IN  in  1  serial line, idle high.
REQ-008 Port: PAR_EN  in  1  parity bit present in frame.
REQ-009 Port: Prescale  in  PRESCALE_W  oversampling ratio; legal values 4, 8, 16, 32.
REQ-010 Port: edge_cnt  in  EDGE_W  edge count from the edge/bit counter; 0..Prescale-1 within each bit.
REQ-011 Port: strt_glitch, par_err, stp_err  in  1 each  checker results, valid in the same cycle as the matching *_chk_en.
REQ-012 Port: cnt_enable  out  1  counter enable; low holds the counter cleared.
REQ-013 Port: dat_samp_en  out  1  sampler enable.
REQ-014 Port: deser_en, strt_chk_en, par_chk_en, stp_chk_en  out  1 each  single-cycle strobes.
REQ-015 Port: data_valid, frame_err  out  1 each  registered single-cycle frame-result pulses.
REQ-016 Port: cfg_err  out  1  registered; Prescale illegal.

Function
REQ-017 States: IDLE, START, DATA, PARITY, STOP.
REQ-018 bit_end is true when edge_cnt == Prescale-1, with Prescale-1 truncated to EDGE_W bits.
REQ-019 cnt_enable and dat_samp_en are 1 in every state except IDLE, decoded from the state register.
REQ-020 IDLE -> START when RX_IN==0 and Prescale is legal; Prescale is captured into pre_q on that edge.
REQ-021 START: on bit_end, strt_chk_en=1; strt_glitch=1 -> IDLE with no pulse; otherwise -> DATA with data index 0.
REQ-022 DATA: on bit_end, deser_en=1 and the index increments; at index DATA_BITS-1 -> PARITY if PAR_EN, else -> STOP.
REQ-023 PARITY: on bit_end, par_chk_en=1, par_err is latched into perr_q, -> STOP.
REQ-024 STOP: on bit_end, stp_chk_en=1, -> IDLE.
REQ-025 On the next cycle: data_valid=1 if !stp_err && !perr_q, else frame_err=1; never both.
REQ-026 Strobes are Mealy outputs (state & bit_end); data_valid/frame_err latency is 1 cycle after stp_chk_en.
REQ-027 PAR_EN is sampled in DATA at the last bit only.
REQ-028 Back-to-back frames: RX_IN low in the IDLE cycle following STOP starts the next frame.
REQ-029 Prescale != pre_q in any non-IDLE state -> IDLE next edge, frame_err pulse, no strobes that cycle.
REQ-030 cfg_err = registered (Prescale illegal); while illegal, IDLE does not leave on RX_IN low.
REQ-031 The data index is $clog2(DATA_BITS) bits and does not wrap within a frame.

Reset
REQ-032 RST=1 at a clock edge -> state IDLE; index, pre_q, perr_q = 0; all outputs 0 the following cycle.
REQ-033 Reset mid-frame aborts the frame without a data_valid or frame_err pulse.
REQ-034 RST dominates every other input in the same cycle.

Configuration
REQ-035 Macro UART_RX_FSM_PARITY_EN defined: PARITY state is present and PAR_EN is honoured.
REQ-036 Macro undefined: PARITY state is absent, PAR_EN is ignored, par_chk_en is tied 0, perr_q is constant 0, and DATA -> STOP always.

Structure
REQ-037 Package uart_rx_pkg holds: the state enum, the legal Prescale constants (4/8/16/32), and the function prescale_legal().
REQ-038 No sub-module; a single always_ff block for state/registers and one combinational decode block.

Verification
REQ-039 Prescale=8, PAR_EN=0, frame 0x55 with a good stop bit -> 8 deser_en pulses 8 cycles apart, data_valid 1 cycle after stp_chk_en, frame_err=0.
REQ-040 Prescale=16, PAR_EN=1, par_err=1 at par_chk_en -> frame_err pulse, no data_valid.
REQ-041 Prescale=4, strt_glitch=1 at edge_cnt=3 of START -> IDLE next cycle, cnt_enable=0, no deser_en.
REQ-042 Prescale changed from 8 to 16 during DATA bit 3 -> IDLE next edge, one frame_err pulse.
REQ-043 Prescale=6 -> cfg_err=1, RX_IN low ignored; then RST asserted at DATA bit 5 of a valid frame -> all outputs 0 next cycle, no pulse.
REQ-044 Two back-to-back frames at Prescale=32 -> two data_valid pulses, both frames captured correctly.
